// File: rtl/hazard_sched.sv
// hazard_sched
// Pipeline hazard scheduler for the 5-stage core. It tracks the instructions
// in EX, MEM and WB in a small scoreboard and uses it to stall decode on RAW
// hazards, because there is no forwarding network. It also flushes IF/ID on
// jumps and taken branches, freezes everything while data memory is busy, and
// drains the pipeline after a halt.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   id_*              decoded fields of the instruction held in IF/ID
//   mem_busy          data memory not ready; freeze the whole pipeline
//   pc_en, ifid_en    PC and IF/ID write enables
//   ifid_flush        load a NOP into IF/ID at the next edge
//   idex_bubble       load a NOP into ID/EX at the next edge
//   pipe_en           EX/MEM and MEM/WB latch enable
//   halted            registered; the core has fully drained after a halt
//   stall_cnt         registered saturating count of stall cycles
//   state             registered; 00 RUN, 01 DRAIN, 10 HALTED
module hazard_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [2:0]  id_rs,
    input  logic [2:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_regWrite,
    input  logic [2:0]  id_writereg,
    input  logic        id_flush,
    input  logic        id_br_taken,
    input  logic        id_halt,
    input  logic        mem_busy,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        pipe_en,
    output logic        halted,
    output logic [15:0] stall_cnt,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic        halted_q, halted_d;
    logic [15:0] stall_q, stall_d;

    // Scoreboard entries: index 0 = EX, 1 = MEM, 2 = WB.
    logic [2:0]      occ_q, occ_d;
    logic [2:0]      wr_q,  wr_d;
    logic [2:0][2:0] dst_q, dst_d;

    logic       hit_rs, hit_rt, hazard;
    logic       ex_occ, ex_wr;
    logic [2:0] ex_dst;

    // WB is not checked: the register file bypasses WB to decode.
    always_comb begin
        hit_rs = (wr_q[0] && (dst_q[0] == id_rs)) || (wr_q[1] && (dst_q[1] == id_rs));
        hit_rt = (wr_q[0] && (dst_q[0] == id_rt)) || (wr_q[1] && (dst_q[1] == id_rt));
        hazard = id_valid && ((id_use_rs && hit_rs) || (id_use_rt && hit_rt));
    end

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_en     = 1'b0;
        ex_occ      = 1'b0;
        ex_wr       = 1'b0;
        ex_dst      = 3'd0;
        state_d     = state_q;
        halted_d    = halted_q;
        stall_d     = stall_q;

        case (state_q)
            ST_RUN: begin
                if (mem_busy || hazard) begin
                    if (stall_q != 16'hFFFF) begin
                        stall_d = stall_q + 16'd1;
                    end
                end
                if (mem_busy) begin
                    // full freeze: every enable stays low
                end else if (hazard) begin
                    // hold PC/IF-ID, let older instructions move on
                    idex_bubble = 1'b1;
                    pipe_en     = 1'b1;
                end else begin
                    pipe_en = 1'b1;
                    ex_occ  = id_valid;
                    ex_wr   = id_valid && id_regWrite;
                    ex_dst  = id_writereg;
                    if (id_valid && id_halt) begin
                        // halt enters EX; nothing behind it is fetched
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                        state_d    = ST_DRAIN;
                    end else if (id_valid && (id_flush || id_br_taken)) begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                    end else begin
                        pc_en   = 1'b1;
                        ifid_en = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                idex_bubble = 1'b1;
                pipe_en     = !mem_busy;
                if (occ_q == 3'b000) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end
            end
            ST_HALTED: begin
                idex_bubble = 1'b1;
                halted_d    = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        occ_d = occ_q;
        wr_d  = wr_q;
        dst_d = dst_q;
        if (pipe_en) begin
            occ_d = {occ_q[1], occ_q[0], ex_occ};
            wr_d  = {wr_q[1], wr_q[0], ex_wr};
            dst_d = {dst_q[1], dst_q[0], ex_dst};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
            stall_q  <= 16'd0;
            occ_q    <= 3'b000;
            wr_q     <= 3'b000;
            dst_q    <= '0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            stall_q  <= stall_d;
            occ_q    <= occ_d;
            wr_q     <= wr_d;
            dst_q    <= dst_d;
        end
    end

    assign halted    = halted_q;
    assign stall_cnt = stall_q;
    assign state     = state_q;

endmodule

// File: tb/tb_hazard_sched.sv
// Directed testbench for hazard_sched: a table of per-cycle decode inputs with
// hand-computed expected enables, state, stall count and halted flag, plus
// hand-written sequences for reset in the middle of a drain and for counter
// saturation.
module tb_hazard_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [2:0]  id_rs = 3'd0;
    logic [2:0]  id_rt = 3'd0;
    logic        id_use_rs = 1'b0;
    logic        id_use_rt = 1'b0;
    logic        id_regWrite = 1'b0;
    logic [2:0]  id_writereg = 3'd0;
    logic        id_flush = 1'b0;
    logic        id_br_taken = 1'b0;
    logic        id_halt = 1'b0;
    logic        mem_busy = 1'b0;
    logic        pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en, halted;
    logic [15:0] stall_cnt;
    logic [1:0]  state;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_regWrite (id_regWrite),
        .id_writereg (id_writereg),
        .id_flush    (id_flush),
        .id_br_taken (id_br_taken),
        .id_halt     (id_halt),
        .mem_busy    (mem_busy),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .pipe_en     (pipe_en),
        .halted      (halted),
        .stall_cnt   (stall_cnt),
        .state       (state)
    );

    // enable bundle order: {pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en}
    localparam logic [4:0] EN_RUN  = 5'b11001;
    localparam logic [4:0] EN_HAZ  = 5'b00011;
    localparam logic [4:0] EN_FL   = 5'b11101;
    localparam logic [4:0] EN_HLT  = 5'b01101;
    localparam logic [4:0] EN_BUSY = 5'b00000;
    localparam logic [4:0] EN_DRN  = 5'b00011;
    localparam logic [4:0] EN_DRNB = 5'b00010;
    localparam logic [4:0] EN_HLTD = 5'b00010;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [2:0]  rs;
        logic        urs;
        logic [2:0]  rt;
        logic        urt;
        logic        rw;
        logic [2:0]  wreg;
        logic        fl;
        logic        br;
        logic        hlt;
        logic        busy;
        logic [4:0]  en;
        logic [1:0]  st;
        logic [15:0] cnt;
        logic        hl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic rst, input logic valid,
                               input logic [2:0] rs, input logic urs,
                               input logic [2:0] rt, input logic urt,
                               input logic rw, input logic [2:0] wreg,
                               input logic fl, input logic br, input logic hlt,
                               input logic busy, input logic [4:0] en,
                               input logic [1:0] st, input logic [15:0] cnt,
                               input logic hl);
        vec_t r;
        r.rst = rst; r.valid = valid; r.rs = rs; r.urs = urs; r.rt = rt;
        r.urt = urt; r.rw = rw; r.wreg = wreg; r.fl = fl; r.br = br;
        r.hlt = hlt; r.busy = busy; r.en = en; r.st = st; r.cnt = cnt; r.hl = hl;
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        id_valid = x.valid; id_rs = x.rs; id_use_rs = x.urs; id_rt = x.rt;
        id_use_rt = x.urt; id_regWrite = x.rw; id_writereg = x.wreg;
        id_flush = x.fl; id_br_taken = x.br; id_halt = x.hlt; mem_busy = x.busy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) begin
            id_valid = 1'($urandom); id_rs = 3'($urandom); id_rt = 3'($urandom);
            id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
            id_regWrite = 1'($urandom); id_writereg = 3'($urandom);
            id_flush = 1'($urandom); id_br_taken = 1'($urandom);
            id_halt = 1'($urandom); mem_busy = 1'($urandom);
            @(negedge clk);
        end
        drive(v(0,0,0,0,0,0,0,0,0,0,0,0,EN_RUN,0,0,0));
        rst_n = 1'b1;
    endtask

    function automatic logic [4:0] en_now();
        return {pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en};
    endfunction

    initial begin
        // Test 1: reset, then back-to-back and one-apart RAW, r0 as a normal register
        vecs.push_back(v(1,0,0,0,0,0,0,0,0,0,0,0,EN_RUN, 0,0,0));
        vecs.push_back(v(0,1,0,0,0,0,1,1,0,0,0,0,EN_RUN, 0,0,0));
        vecs.push_back(v(0,1,1,1,0,0,0,0,0,0,0,0,EN_HAZ, 0,0,0));
        vecs.push_back(v(0,1,1,1,0,0,0,0,0,0,0,0,EN_HAZ, 0,1,0));
        vecs.push_back(v(0,1,1,1,0,0,0,0,0,0,0,0,EN_RUN, 0,2,0));
        vecs.push_back(v(0,1,0,0,0,0,1,2,0,0,0,0,EN_RUN, 0,2,0));
        vecs.push_back(v(0,1,2,0,2,0,0,0,0,0,0,0,EN_RUN, 0,2,0));
        vecs.push_back(v(0,1,0,0,2,1,0,0,0,0,0,0,EN_HAZ, 0,2,0));
        vecs.push_back(v(0,1,0,0,2,1,0,0,0,0,0,0,EN_RUN, 0,3,0));
        vecs.push_back(v(0,1,0,0,0,0,1,0,0,0,0,0,EN_RUN, 0,3,0));
        vecs.push_back(v(0,1,0,0,5,1,0,0,0,0,0,0,EN_RUN, 0,3,0));
        vecs.push_back(v(0,1,0,1,0,0,0,0,0,0,0,0,EN_HAZ, 0,3,0));
        vecs.push_back(v(0,1,0,1,0,0,0,0,0,0,0,0,EN_RUN, 0,4,0));
        // jump, then taken branch behind a hazard
        vecs.push_back(v(0,1,0,0,0,0,0,0,1,0,0,0,EN_FL,  0,4,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,0,0,0,0,EN_RUN, 0,4,0));
        vecs.push_back(v(0,1,0,0,0,0,1,3,0,0,0,0,EN_RUN, 0,4,0));
        vecs.push_back(v(0,1,3,1,0,0,0,0,0,1,0,0,EN_HAZ, 0,4,0));
        vecs.push_back(v(0,1,3,1,0,0,0,0,0,1,0,0,EN_HAZ, 0,5,0));
        vecs.push_back(v(0,1,3,1,0,0,0,0,0,1,0,0,EN_FL,  0,6,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,0,0,0,0,EN_RUN, 0,6,0));
        // mem_busy freeze on top of a pending hazard
        vecs.push_back(v(0,1,0,0,0,0,1,4,0,0,0,0,EN_RUN, 0,6,0));
        vecs.push_back(v(0,1,4,1,0,0,0,0,0,0,0,1,EN_BUSY,0,6,0));
        vecs.push_back(v(0,1,4,1,0,0,0,0,0,0,0,1,EN_BUSY,0,7,0));
        vecs.push_back(v(0,1,4,1,0,0,0,0,0,0,0,1,EN_BUSY,0,8,0));
        vecs.push_back(v(0,1,4,1,0,0,0,0,0,0,0,0,EN_HAZ, 0,9,0));
        vecs.push_back(v(0,1,4,1,0,0,0,0,0,0,0,0,EN_HAZ, 0,10,0));
        vecs.push_back(v(0,1,4,1,0,0,0,0,0,0,0,0,EN_RUN, 0,11,0));
        // halt with two writers in flight: halted after E4
        vecs.push_back(v(0,1,0,0,0,0,1,5,0,0,0,0,EN_RUN, 0,11,0));
        vecs.push_back(v(0,1,0,0,0,0,1,6,0,0,0,0,EN_RUN, 0,11,0));
        vecs.push_back(v(0,1,0,0,0,0,0,0,0,0,1,0,EN_HLT, 0,11,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,0,0,0,0,EN_DRN, 1,11,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,0,0,0,0,EN_DRN, 1,11,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,0,0,0,0,EN_DRN, 1,11,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,0,0,0,0,EN_DRN, 1,11,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,0,0,0,0,EN_HLTD,2,11,1));
        vecs.push_back(v(0,1,6,1,0,0,0,0,0,0,0,1,EN_HLTD,2,11,1));
        vecs.push_back(v(0,0,0,0,0,0,0,0,0,0,0,0,EN_HLTD,2,11,1));
        // halt with 2 mem_busy cycles during DRAIN: halted after E6
        vecs.push_back(v(1,1,0,0,0,0,1,1,0,0,0,0,EN_RUN, 0,0,0));
        vecs.push_back(v(0,1,0,0,0,0,1,2,0,0,0,0,EN_RUN, 0,0,0));
        vecs.push_back(v(0,1,0,0,0,0,0,0,0,0,1,0,EN_HLT, 0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,0,0,0,1,EN_DRNB,1,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,0,0,0,1,EN_DRNB,1,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,0,0,0,0,EN_DRN, 1,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,0,0,0,0,EN_DRN, 1,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,0,0,0,0,EN_DRN, 1,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,0,0,0,0,EN_DRN, 1,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,0,0,0,0,EN_HLTD,2,0,1));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            @(negedge clk);
            drive(vecs[i]);
            #1;
            $display("[TB] vec %0d en=%b state=%0d stall_cnt=%0d halted=%0d",
                     i, en_now(), state, stall_cnt, halted);
            check($sformatf("vec%0d enables", i), {11'd0, en_now()}, {11'd0, vecs[i].en});
            check($sformatf("vec%0d state", i), {14'd0, state}, {14'd0, vecs[i].st});
            check($sformatf("vec%0d stall_cnt", i), stall_cnt, vecs[i].cnt);
            check($sformatf("vec%0d halted", i), {15'd0, halted}, {15'd0, vecs[i].hl});
        end

        // Reset in the middle of DRAIN while the halt (writing r7) sits in MEM
        do_reset();
        @(negedge clk);
        drive(v(0,1,0,0,0,0,1,1,0,0,0,0,EN_RUN,0,0,0));
        @(negedge clk);
        drive(v(0,1,0,0,0,0,1,7,0,0,1,0,EN_HLT,0,0,0));
        #1;
        check("middrain halt accept", {11'd0, en_now()}, {11'd0, EN_HLT});
        @(negedge clk);
        drive(v(0,0,0,0,0,0,0,0,0,0,0,0,EN_DRN,1,0,0));
        #1;
        check("middrain state drain", {14'd0, state}, 16'd1);
        @(negedge clk);
        drive(v(0,1,7,1,0,0,0,0,0,0,0,0,EN_RUN,0,0,0));
        rst_n = 1'b0;
        #1;
        $display("[TB] middrain reset en=%b state=%0d", en_now(), state);
        check("middrain reset state", {14'd0, state}, 16'd0);
        check("middrain reset enables", {11'd0, en_now()}, {11'd0, EN_RUN});
        check("middrain reset halted", {15'd0, halted}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("middrain after release", {11'd0, en_now()}, {11'd0, EN_RUN});

        // stall_cnt saturation under a long mem_busy
        do_reset();
        @(negedge clk);
        mem_busy = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        $display("[TB] saturation step stall_cnt=%0d", stall_cnt);
        check("sat pre", stall_cnt, 16'hFFFE);
        check("sat busy enables", {11'd0, en_now()}, {11'd0, EN_BUSY});
        repeat (2) @(posedge clk);
        #1;
        check("sat reached", stall_cnt, 16'hFFFF);
        repeat (4464) @(posedge clk);
        #1;
        $display("[TB] saturation end stall_cnt=%0d", stall_cnt);
        check("sat held", stall_cnt, 16'hFFFF);
        mem_busy = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_sched.md
# hazard_sched

Pipeline hazard scheduler for the 5-stage core. Sits beside the decode stage and uses that stage's decoded fields (source/destination registers, regWrite, flush, halt) to keep a 3-entry in-flight scoreboard (EX, MEM, WB). From that scoreboard it drives the PC, IF/ID and ID/EX enables. It handles:
- RAW stalls (there is no forwarding network; the bypassing register file covers only WB→decode);
- jump/branch flushes;
- memory-busy freezes;
- halt draining.

## Interface
- No parameters.
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  IF/ID holds a real instruction
- id_rs, id_rt  in  3 each  decode source register selects (instr[10:8], instr[7:5])
- id_use_rs, id_use_rt  in  1 each  instruction actually reads that source
- id_regWrite  in  1  instruction writes the register file
- id_writereg  in  3  destination register
- id_flush  in  1  jump or jumpReg decoded
- id_br_taken  in  1  branch decoded and condition true
- id_halt  in  1  halt decoded
- mem_busy  in  1  data memory not ready; freeze the pipeline
- pc_en  out  1  PC register write enable
- ifid_en  out  1  IF/ID latch enable
- ifid_flush  out  1  load NOP into IF/ID at the next edge
- idex_bubble  out  1  load NOP into ID/EX at the next edge
- pipe_en  out  1  EX/MEM and MEM/WB latch enable
- halted  out  1  core fully drained after halt
- stall_cnt  out  16  saturating count of stall cycles
- state  out  2  00 RUN, 01 DRAIN, 10 HALTED

## Operation

**Scoreboard.** Three entries: EX, MEM, WB. Each entry holds occ, wr and reg[2:0].
- Shifting happens only when pipe_en=1: EX→MEM→WB, and WB is discarded.
- EX load value:
  - RUN with no hazard: occ=id_valid, wr=id_valid&id_regWrite, reg=id_writereg.
  - Otherwise (hazard, DRAIN, HALTED): all zero.

**Hazard detection.**
- hit(r) = (EX.wr & EX.reg==r) | (MEM.wr & MEM.reg==r). WB is excluded because the register file bypasses it.
- hazard = id_valid & ((id_use_rs & hit(id_rs)) | (id_use_rt & hit(id_rt))). r0 is an ordinary register, with no special case.

**Outputs by state.**
- RUN, mem_busy=1 (highest priority): pc_en=0, ifid_en=0, pipe_en=0, ifid_flush=0, idex_bubble=0. Everything holds.
- RUN, hazard: pc_en=0, ifid_en=0, idex_bubble=1, pipe_en=1, ifid_flush=0. A hazard suppresses any flush or halt in the same cycle.
- RUN, id_valid & id_halt: pc_en=0, ifid_flush=1, pipe_en=1. At the edge, state←DRAIN. The halt instruction itself enters EX.
- RUN, id_valid & (id_flush | id_br_taken): pc_en=1, ifid_en=1, ifid_flush=1, pipe_en=1.
- RUN, otherwise: pc_en=1, ifid_en=1, pipe_en=1, others 0.
- DRAIN: pc_en=0, ifid_en=0, idex_bubble=1, pipe_en=~mem_busy.
  - When EX.occ, MEM.occ and WB.occ are all 0, state←HALTED at the next edge.
- HALTED: all enables 0, idex_bubble=1, halted=1. Only reset leaves this state.

**stall_cnt.**
- Increments each RUN cycle with hazard=1 or mem_busy=1.
- Saturates at 16'hFFFF.
- Frozen in DRAIN and HALTED.

## Timing
- **Reset** (async assert, deasserted synchronously by the environment):
  - state=RUN, scoreboard cleared, stall_cnt=0, halted=0.
  - With id_valid=0 this gives pc_en=1, ifid_en=1, pipe_en=1 and ifid_flush=idex_bubble=0.
- **Registered vs combinational.** All outputs except halted, state and stall_cnt are combinational from the current state, the scoreboard and this cycle's decode inputs. halted, state and stall_cnt are registered.
- **RAW stall lengths:**
  - Dependent instruction immediately after its writer: 2 stall cycles.
  - One instruction between them: 1 stall cycle.
  - Two or more between: 0 stall cycles.
  - mem_busy cycles add on top and are counted.
- **Flushes:**
  - A flush costs exactly one bubble cycle.
  - A branch behind a hazard flushes only in the first non-hazard cycle.
- **Halt timing:**
  - Call the edge that accepts the halt E0. halted=1 after edge E4, assuming no mem_busy.
  - Each mem_busy cycle during DRAIN delays halted by one cycle.
- **Reset mid-DRAIN:** returns immediately to RUN with the scoreboard empty.

## Test plan
1. **Reset:** hold rst_n=0 with random inputs, then release with id_valid=0. Expect state=00, pc_en=1, ifid_en=1, pipe_en=1, halted=0, stall_cnt=0.
2. **Back-to-back RAW:** issue a writer of r1, then a reader with id_rs=1, use_rs=1. Expect pc_en=0 and idex_bubble=1 for exactly 2 cycles, the reader then issues, and stall_cnt=2. Repeat with one independent instruction between them: expect 1 stall cycle.
3. **Jump and branch behind hazard:**
   - id_flush=1 with no hazard: ifid_flush=1 for 1 cycle, pc_en=1, stall_cnt unchanged.
   - Branch on r3 directly after a writer of r3 with id_br_taken=1: 2 stall cycles with ifid_flush=0, then 1 cycle with ifid_flush=1.
4. **mem_busy freeze:** assert mem_busy for 3 cycles while a hazard is pending. Expect all enables 0 and the scoreboard unchanged. stall_cnt counts 3 busy cycles plus the remaining hazard cycles.
5. **Halt drain:**
   - With two writers in flight, accept halt at E0. Expect state=01 after E0, halted=1 after E4, and pc_en=0 throughout.
   - Repeat with 2 mem_busy cycles during DRAIN: halted after E6.
6. **Reset mid-DRAIN and saturation:**
   - Pull rst_n low two cycles after the halt is accepted. Expect state=00 and the scoreboard clear immediately.
   - Force 70000 mem_busy cycles. Expect stall_cnt=16'hFFFF.
